// File: rtl/alu_mul_unit_pkg.sv
// Shared definitions for the RV64M multiply unit: datapath width, op
// encodings and the operand sign-extension decode.
package alu_mul_unit_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] MUL_OP_MUL    = 3'd0;
  localparam logic [2:0] MUL_OP_MULH   = 3'd1;
  localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
  localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
  localparam logic [2:0] MUL_OP_MULW   = 3'd4;

  // rs1 is treated as signed only for the signed-high variants.
  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is signed only for MULH; MUL/MULW low halves are sign-agnostic.
  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_result_fmt.sv
// Selects the architectural result from the (low 2*XLEN bits of the)
// extended-operand product according to the multiply op.
module mul_result_fmt
  import alu_mul_unit_pkg::*;
#(
  parameter int W = alu_mul_unit_pkg::XLEN
) (
  input  logic [2:0]     op_i,
  input  logic [2*W-1:0] prod_i,
  output logic [W-1:0]   result_o
);

  // Half/word selection; reserved encodings produce zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      MUL_OP_MUL:    result_o = prod_i[W-1:0];
      MUL_OP_MULH,
      MUL_OP_MULHSU,
      MUL_OP_MULHU:  result_o = prod_i[2*W-1:W];
      MUL_OP_MULW:   result_o = {{(W/2){prod_i[W/2-1]}}, prod_i[W/2-1:0]};
      default:       result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_unit.sv
// Two-stage pipelined RV64M multiplier: S1 registers the op and the
// 65-bit extended operands, S2 registers the formatted product.
// Valid/ready on both sides, fixed 2-cycle latency, flush kills all.
module alu_mul_unit
  import alu_mul_unit_pkg::*;
#(
  parameter int XLEN  = alu_mul_unit_pkg::XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       mul_op_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int PROD_W = 2 * XLEN;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic [XLEN:0]    s1_a_q,     s1_a_d;
  logic [XLEN:0]    s1_b_q,     s1_b_d;

  // Stage 2 state
  logic             s2_valid_q,  s2_valid_d;
  logic [XLEN-1:0]  s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

  logic adv1, adv2, accept;
  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   fmt_result;

  // Pipeline advance and upstream ready; never looks at in_valid_i.
  always_comb begin
    adv2       = !s2_valid_q || out_ready_i;
    adv1       = s1_valid_q && adv2;
    in_ready_o = !s1_valid_q || adv2;
    accept     = in_valid_i && in_ready_o && !flush_i;
  end

  // Sign-extend the 65-bit operands to the product width so a plain
  // unsigned multiply yields the correct low 2*XLEN bits for every op.
  always_comb begin
    a_ext = {{(PROD_W-XLEN-1){s1_a_q[XLEN]}}, s1_a_q};
    b_ext = {{(PROD_W-XLEN-1){s1_b_q[XLEN]}}, s1_b_q};
    prod  = a_ext * b_ext;
  end

  mul_result_fmt #(
    .W (XLEN)
  ) u_fmt (
    .op_i     (s1_op_q),
    .prod_i   (prod),
    .result_o (fmt_result)
  );

  // Next-state for both stages; data registers load only on advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_tag_d    = s1_tag_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;

    if (accept) begin
      s1_op_d  = mul_op_i;
      s1_tag_d = tag_i;
      s1_a_d   = {rs1_is_signed(mul_op_i) & rs1_data_i[XLEN-1], rs1_data_i};
      s1_b_d   = {rs2_is_signed(mul_op_i) & rs2_data_i[XLEN-1], rs2_data_i};
    end
    if (adv1) begin
      s2_result_d = fmt_result;
      s2_tag_d    = s1_tag_q;
    end

    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)    s1_valid_d = 1'b1;
      else if (adv1) s1_valid_d = 1'b0;
      if (adv2)      s2_valid_d = s1_valid_q;
    end
  end

  // State registers with synchronous reset that clears data as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign result_o    = s2_result_q;
  assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_alu_mul_unit.sv
// Scoreboard bench for alu_mul_unit: expected {result,tag} pushed at accept,
// popped and compared by a monitor at every output handshake.
module tb_alu_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  mul_op_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic [4:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic [4:0]  tag_o;

  int vectors    = 0;
  int miscompares = 0;
  int delivered  = 0;
  logic [68:0] sb[$];

  alu_mul_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mul_op_i    (mul_op_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o)
  );

  always #5 clk = ~clk;

  // Independent reference built from 128-bit two's-complement arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    case (op)
      3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      3'd4: begin p = {64'b0, a} * {64'b0, b}; return {{32{p[31]}}, p[31:0]}; end
      default: return 64'd0;
    endcase
  endfunction

  // Output monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got result=%h tag=%0d, required no output", result_o, tag_o);
      end else begin
        logic [68:0] exp;
        exp = sb.pop_front();
        if ({result_o, tag_o} !== exp) begin
          miscompares++;
          $display("FAIL scoreboard: got result=%h tag=%0d, required result=%h tag=%0d",
                   result_o, tag_o, exp[68:5], exp[4:0]);
        end
      end
      delivered++;
      $display("out  result=%h tag=%0d", result_o, tag_o);
    end
  end

  // Present one op until accepted (bounded); pushes its expectation.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] t, input logic [63:0] exp);
    bit acc = 0;
    in_valid_i = 1'b1; mul_op_i = op; rs1_data_i = a; rs2_data_i = b; tag_i = t;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        sb.push_back({exp, t});
        acc = 1;
        $display("in   op=%0d a=%h b=%h tag=%0d", op, a, b, t);
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic wait_drain;
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    mul_op_i = '0; rs1_data_i = '0; rs2_data_i = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({out_valid_o, result_o, tag_o} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid_o, result_o, tag_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 1", in_ready_o);
    end
  endtask

  task automatic test_mul;
    send(3'd0, 64'd3, 64'd5, 5'd9, 64'd15);
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid_o);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_o, result_o, tag_o} !== {1'b1, 64'd15, 5'd9}) begin
      miscompares++;
      $display("FAIL latency_mul: got valid=%b result=%h tag=%0d, required 1/15/9", out_valid_o, result_o, tag_o);
    end
    wait_drain();
  endtask

  task automatic test_ops;
    send(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'd0);
    send(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    send(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    send(3'd4, 64'h7FFF_FFFF,           64'd2,                  5'd4, 64'hFFFF_FFFF_FFFF_FFFE);
    send(3'd6, 64'd123,                 64'd456,                5'd5, 64'd0);
    wait_drain();
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    bit dropped = 0;
    int start = delivered;
    logic [63:0] held_res;
    logic [4:0]  held_tag;
    for (int c = 0; c < 14; c++) begin
      out_ready_i = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        in_valid_i = 1'b1; mul_op_i = 3'd0;
        rs1_data_i = 64'(idx + 1); rs2_data_i = 64'd10; tag_i = 5'(idx + 10);
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk);
      if (c == 3) begin held_res = result_o; held_tag = tag_o; end
      if (c == 4 || c == 5) begin
        vectors++;
        if ({out_valid_o, result_o, tag_o} !== {1'b1, held_res, held_tag}) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b result=%h tag=%0d, required 1/%h/%0d",
                   out_valid_o, result_o, tag_o, held_res, held_tag);
        end
      end
      if (in_valid_i && !in_ready_o) dropped = 1;
      if (in_valid_i && in_ready_o) begin
        sb.push_back({64'(idx + 1) * 64'd10, 5'(idx + 10)});
        $display("in   op=0 a=%0d b=10 tag=%0d", idx + 1, idx + 10);
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    vectors++;
    if (dropped !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_drop: got %b, required 1", dropped);
    end
    wait_drain();
    vectors++;
    if (delivered - start !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d, required 4", delivered - start);
    end
  endtask

  task automatic test_flush;
    out_ready_i = 1'b0;
    send(3'd0, 64'd11, 64'd11, 5'd1, 64'd121);
    send(3'd0, 64'd12, 64'd12, 5'd2, 64'd144);
    in_valid_i = 1'b1; mul_op_i = 3'd0; rs1_data_i = 64'd13; rs2_data_i = 64'd13; tag_i = 5'd3;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb.delete();
    vectors++;
    if (out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got %b, required 0", out_valid_o);
    end
    out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_ghost: got out_valid=%b result=%h, required 0", out_valid_o, result_o);
      end
    end
    send(3'd0, 64'd7, 64'd6, 5'd7, 64'd42);
    wait_drain();
  endtask

  task automatic test_reset_mid;
    out_ready_i = 1'b0;
    send(3'd0, 64'd9, 64'd9, 5'd21, 64'd81);
    send(3'd0, 64'd8, 64'd8, 5'd22, 64'd64);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_o, result_o, tag_o} !== 70'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid_o, result_o, tag_o);
    end
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_ready: got %b, required 1", in_ready_o);
    end
    out_ready_i = 1'b1;
    send(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd23, 64'd1);
    wait_drain();
  endtask

  task automatic test_random;
    bit done = 0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          logic [2:0]  op;
          logic [63:0] a, b;
          op = 3'($urandom_range(0, 7));
          a  = {$urandom, $urandom};
          b  = {$urandom, $urandom};
          send(op, a, b, 5'(n), model(op, a, b));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready_i = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
